time_set_controller: RTL and testbench
======================================

# time_set_controller

Button-driven time-setting sequencer for the clock display path. It sits between the debounced button-event logic and `clock_counter`. It freezes the running time, lets the user step through hour/minute/second fields with short presses, and commits the edited value to the counter with a one-cycle load strobe. It also drives field-select and blink outputs so `text_renderer_enhanced` can highlight the field being edited.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 270000000: idle cycles in any edit state before the edit is abandoned (10 s at 27 MHz).
- `BLINK_CYCLES`, default 6750000: half-period of `blink_on` (250 ms at 27 MHz).

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `short_press`  in  1  one-cycle pulse: debounced short press.
- `long_press`  in  1  one-cycle pulse: debounced long press.
- `cur_hour`  in  5  live hour from `clock_counter`, 0..23.
- `cur_min`  in  6  live minute, 0..59.
- `cur_sec`  in  6  live second, 0..59.
- `set_hour`  out  5  edited hour (shadow register).
- `set_min`  out  6  edited minute.
- `set_sec`  out  6  edited second.
- `load`  out  1  one-cycle strobe; `clock_counter` copies `set_*` on this cycle.
- `run_en`  out  1  1 = counter may advance; 0 = counter is frozen.
- `edit_field`  out  2  0 = none, 1 = hour, 2 = minute, 3 = second.
- `blink_on`  out  1  highlight phase for the selected field; 0 outside the edit states.

## Operation
- States: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT. All outputs are registered.
- RUN:
  - `run_en`=1, `edit_field`=0.
  - `long_press` copies `cur_hour`/`cur_min`/`cur_sec` into `set_*` and moves to EDIT_H.
  - `short_press` is ignored.
- EDIT_H / EDIT_M / EDIT_S:
  - `run_en`=0, `edit_field`=1/2/3.
  - `short_press` increments the selected field modulo its range: hour 23→0, minute 59→0, second 59→0. Other fields are unchanged.
  - `long_press` advances EDIT_H→EDIT_M→EDIT_S→COMMIT.
- COMMIT: `load`=1 and `run_en`=0 for exactly one cycle, then unconditionally RUN. Inputs in COMMIT are ignored.
- Simultaneous `short_press` and `long_press` in the same cycle: `long_press` wins and the field is not incremented.
- Timeout:
  - The idle counter clears on edit entry and on any press.
  - It increments every edit-state cycle without a press.
  - When `TIMEOUT_CYCLES` consecutive idle cycles elapse, the state returns to RUN with no `load`. `set_*` keep the abandoned values and are not written to the counter.
- Blink:
  - `blink_on` is set to 1 and its divider cleared on edit entry, on any press, and on each field change.
  - It then toggles every `BLINK_CYCLES` cycles.
  - It is forced to 0 in RUN and COMMIT.
- `set_*` change only on edit entry (capture) or on an increment. They are stable through COMMIT and afterwards.
- Counter widths: `$clog2(TIMEOUT_CYCLES+1)` and `$clog2(BLINK_CYCLES+1)`. Wrap compares are exact-equality on the field maximum. No overflow is possible.

## Timing
- Reset values: state RUN, `run_en`=1, `load`=0, `set_hour`/`set_min`/`set_sec`=0, `edit_field`=0, `blink_on`=0, both counters 0.
- `rst` is asserted mid-edit or during COMMIT: the next cycle is RUN with the reset values, and no `load` is issued.
- `long_press` in RUN at cycle N:
  - At N+1: EDIT_H, `run_en`=0, `edit_field`=1, `blink_on`=1.
  - `set_*` equal the `cur_*` values sampled at N.
- `short_press` at cycle N in an edit state: the new field value is visible at N+1.
- `long_press` in EDIT_S at cycle N:
  - N+1: `load`=1, `run_en`=0.
  - N+2: `load`=0, `run_en`=1, `edit_field`=0.
- Timeout: last press (or entry) at cycle N gives RUN at cycle N+`TIMEOUT_CYCLES`+1.
- Throughput: one press is accepted per cycle. Back-to-back `short_press` pulses each increment.

## Test plan
Run with `TIMEOUT_CYCLES`=100 and `BLINK_CYCLES`=8.
- Full edit: `cur`=12:34:56, then long, short×3, long, short×2, long, long → exactly one `load` pulse with `set`=15:36:56, then `run_en`=1.
- Wrap: `cur`=23:59:59, then long, short → hour 0; long, short → minute 0; long, short → second 0; long → `load` with 00:00:00.
- Timeout: long, short, then 100 idle cycles → RUN with `run_en`=1 and no `load`. A `short_press` after that does not change `set_hour`.
- Simultaneous: in EDIT_H with `set_hour`=5, pulse short and long in the same cycle → EDIT_M and `set_hour` still 5.
- Reset mid-edit: assert `rst` in EDIT_M → next cycle RUN, `set_*`=0, `load` never asserted.
- Blink: in EDIT_H with no press → `blink_on` toggles every 8 cycles. A `short_press` returns it to 1 and restarts the period. `blink_on`=0 in RUN.

Source files
------------

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - button-driven time-setting sequencer for the clock display path
//
// Freezes the running time on a long press, lets short presses step the
// selected hour/minute/second field, and commits the edited value to
// clock_counter with a one-cycle load strobe. Every output is registered.
//
// Ports:
//   clk          pixel clock, the only clock
//   rst          synchronous active-high reset
//   short_press  one-cycle debounced short-press pulse
//   long_press   one-cycle debounced long-press pulse
//   cur_hour/min/sec  live time from clock_counter
//   set_hour/min/sec  edited time (shadow registers)
//   load         one-cycle strobe; clock_counter copies set_* on this cycle
//   run_en       1 = counter may advance, 0 = frozen
//   edit_field   0 none, 1 hour, 2 minute, 3 second
//   blink_on     highlight phase of the selected field, 0 outside edit states
module time_set_controller #(
  parameter int TIMEOUT_CYCLES = 270000000,
  parameter int BLINK_CYCLES   = 6750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       short_press,
  input  logic       long_press,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       run_en,
  output logic [1:0] edit_field,
  output logic       blink_on
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  // Terminal counts: the counter value seen on the last idle cycle before
  // the timeout / blink toggle takes effect on the next edge.
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_ONE   = TW'(1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  // Edit-state codes are chosen so their low two bits equal edit_field.
  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_EDIT_H = 3'd1;
  localparam logic [2:0] S_EDIT_M = 3'd2;
  localparam logic [2:0] S_EDIT_S = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [4:0]    set_hour_q, set_hour_d;
  logic [5:0]    set_min_q, set_min_d;
  logic [5:0]    set_sec_q, set_sec_d;
  logic          load_q, load_d;
  logic          run_en_q, run_en_d;
  logic [1:0]    edit_field_q, edit_field_d;
  logic          blink_on_q, blink_on_d;
  logic          edit_next;

  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    blink_cnt_d = blink_cnt_q;
    set_hour_d  = set_hour_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;
    blink_on_d  = blink_on_q;

    case (state_q)
      S_RUN: begin
        if (long_press) begin
          state_d     = S_EDIT_H;
          set_hour_d  = cur_hour;
          set_min_d   = cur_min;
          set_sec_d   = cur_sec;
          idle_d      = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end
      end

      S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
        if (long_press) begin
          // long wins over a simultaneous short: no increment here
          state_d     = (state_q == S_EDIT_S) ? S_COMMIT : state_q + 3'd1;
          idle_d      = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (short_press) begin
          case (state_q)
            S_EDIT_H: set_hour_d = (set_hour_q == 5'd23) ? 5'd0 : set_hour_q + 5'd1;
            S_EDIT_M: set_min_d  = (set_min_q  == 6'd59) ? 6'd0 : set_min_q  + 6'd1;
            default:  set_sec_d  = (set_sec_q  == 6'd59) ? 6'd0 : set_sec_q  + 6'd1;
          endcase
          idle_d      = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (idle_q == IDLE_LAST) begin
          // abandon the edit; set_* keep the partial values but no load
          state_d     = S_RUN;
          idle_d      = '0;
          blink_cnt_d = '0;
        end else begin
          idle_d = idle_q + IDLE_ONE;
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_ONE;
          end
        end
      end

      S_COMMIT: state_d = S_RUN;

      default: state_d = S_RUN;
    endcase

    // Outputs are registered, so they are derived from the next state.
    edit_next    = (state_d == S_EDIT_H) || (state_d == S_EDIT_M) || (state_d == S_EDIT_S);
    run_en_d     = (state_d == S_RUN);
    load_d       = (state_d == S_COMMIT);
    edit_field_d = edit_next ? state_d[1:0] : 2'd0;
    if (!edit_next) begin
      blink_on_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      idle_q       <= '0;
      blink_cnt_q  <= '0;
      set_hour_q   <= '0;
      set_min_q    <= '0;
      set_sec_q    <= '0;
      load_q       <= 1'b0;
      run_en_q     <= 1'b1;
      edit_field_q <= 2'd0;
      blink_on_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      blink_cnt_q  <= blink_cnt_d;
      set_hour_q   <= set_hour_d;
      set_min_q    <= set_min_d;
      set_sec_q    <= set_sec_d;
      load_q       <= load_d;
      run_en_q     <= run_en_d;
      edit_field_q <= edit_field_d;
      blink_on_q   <= blink_on_d;
    end
  end

  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign set_sec    = set_sec_q;
  assign load       = load_q;
  assign run_en     = run_en_q;
  assign edit_field = edit_field_q;
  assign blink_on   = blink_on_q;

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - self-checking bench for time_set_controller
module tb_time_set_controller;

  localparam int TO = 100;
  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       short_press = 1'b0;
  logic       long_press = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       load;
  logic       run_en;
  logic [1:0] edit_field;
  logic       blink_on;

  int checks = 0;
  int errors = 0;
  int load_seen = 0;

  // Reference model: mode 0 run, 1..3 editing hour/min/sec, 4 commit.
  // m_since counts cycles since the last blink restart; blink phase is
  // derived from it arithmetically.
  int m_mode = 0;
  int m_h = 0, m_m = 0, m_s = 0;
  int m_idle = 0, m_since = 0;

  time_set_controller #(.TIMEOUT_CYCLES(TO), .BLINK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .short_press(short_press), .long_press(long_press),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .load(load), .run_en(run_en), .edit_field(edit_field), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic s, input logic l, input logic r);
    if (r) begin
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_since = 0;
    end else if (m_mode == 0) begin
      if (l) begin
        m_mode = 1; m_h = int'(cur_hour); m_m = int'(cur_min); m_s = int'(cur_sec);
        m_idle = 0; m_since = 0;
      end
    end else if (m_mode == 4) begin
      m_mode = 0;
    end else begin
      if (l) begin
        m_mode = m_mode + 1; m_idle = 0; m_since = 0;
      end else if (s) begin
        if (m_mode == 1) m_h = (m_h + 1) % 24;
        else if (m_mode == 2) m_m = (m_m + 1) % 60;
        else m_s = (m_s + 1) % 60;
        m_idle = 0; m_since = 0;
      end else begin
        m_idle++; m_since++;
        if (m_idle == TO) m_mode = 0;
      end
    end
  endtask

  function automatic logic exp_blink();
    return (m_mode >= 1 && m_mode <= 3) && ((m_since / BL) % 2 == 0);
  endfunction

  function automatic logic [1:0] exp_field();
    return (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
  endfunction

  // One clock: inputs held across the edge, outputs settle and are sampled 1 time unit later.
  task automatic step(input logic s, input logic l, input logic r);
    short_press = s; long_press = l; rst = r;
    @(posedge clk);
    model_update(s, l, r);
    #1;
    if (load === 1'b1) load_seen++;
    short_press = 1'b0; long_press = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (run_en !== 1'b1 || load !== 1'b0 || edit_field !== 2'd0 || blink_on !== 1'b0 ||
        set_hour !== 5'd0 || set_min !== 6'd0 || set_sec !== 6'd0) begin
      errors++;
      $display("FAIL reset got run_en=%b load=%b field=%0d blink=%b set=%0d:%0d:%0d want 1 0 0 0 0:0:0",
               run_en, load, edit_field, blink_on, set_hour, set_min, set_sec);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (run_en !== 1'b1 || edit_field !== 2'd0 || set_hour !== 5'd0) begin
      errors++;
      $display("FAIL short_in_run got run_en=%b field=%0d hour=%0d want 1 0 0", run_en, edit_field, set_hour);
    end
  endtask

  task automatic test_full_edit();
    step(1'b0, 1'b0, 1'b1);
    load_seen = 0;
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    step(1'b0, 1'b1, 1'b0);
    cur_hour = 5'd3; cur_min = 6'd4; cur_sec = 6'd5;
    checks++;
    if (set_hour !== 5'd12 || set_min !== 6'd34 || set_sec !== 6'd56 || edit_field !== 2'd1 ||
        run_en !== 1'b0 || blink_on !== 1'b1) begin
      errors++;
      $display("FAIL full_capture got %0d:%0d:%0d field=%0d run_en=%b blink=%b want 12:34:56 1 0 1",
               set_hour, set_min, set_sec, edit_field, run_en, blink_on);
    end
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (edit_field !== 2'd3 || set_hour !== 5'd15 || set_min !== 6'd36 || set_sec !== 6'd56) begin
      errors++;
      $display("FAIL full_fields got field=%0d %0d:%0d:%0d want 3 15:36:56", edit_field, set_hour, set_min, set_sec);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (load !== 1'b1 || run_en !== 1'b0 || set_hour !== 5'd15 || set_min !== 6'd36 || set_sec !== 6'd56) begin
      errors++;
      $display("FAIL full_commit got load=%b run_en=%b %0d:%0d:%0d want 1 0 15:36:56",
               load, run_en, set_hour, set_min, set_sec);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (load !== 1'b0 || run_en !== 1'b1 || edit_field !== 2'd0 || set_hour !== 5'd15) begin
      errors++;
      $display("FAIL full_after got load=%b run_en=%b field=%0d hour=%0d want 0 1 0 15",
               load, run_en, edit_field, set_hour);
    end
    repeat (5) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (load_seen !== 1) begin
      errors++;
      $display("FAIL full_load_count got %0d want 1", load_seen);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1);
    load_seen = 0;
    cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd59;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (set_hour !== 5'd0 || set_min !== 6'd59) begin
      errors++;
      $display("FAIL wrap_hour got %0d:%0d want 0:59", set_hour, set_min);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (set_min !== 6'd0 || set_sec !== 6'd59) begin
      errors++;
      $display("FAIL wrap_min got min=%0d sec=%0d want 0 59", set_min, set_sec);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (load !== 1'b1 || set_hour !== 5'd0 || set_min !== 6'd0 || set_sec !== 6'd0) begin
      errors++;
      $display("FAIL wrap_commit got load=%b %0d:%0d:%0d want 1 0:0:0", load, set_hour, set_min, set_sec);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [4:0] hold;
    step(1'b0, 1'b0, 1'b1);
    load_seen = 0;
    cur_hour = 5'd7; cur_min = 6'd20; cur_sec = 6'd30;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (TO - 1) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (run_en !== 1'b0 || edit_field !== 2'd1) begin
      errors++;
      $display("FAIL timeout_early got run_en=%b field=%0d want 0 1", run_en, edit_field);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (run_en !== 1'b1 || edit_field !== 2'd0 || blink_on !== 1'b0 || load_seen !== 0 || set_hour !== 5'd8) begin
      errors++;
      $display("FAIL timeout_run got run_en=%b field=%0d blink=%b loads=%0d hour=%0d want 1 0 0 0 8",
               run_en, edit_field, blink_on, load_seen, set_hour);
    end
    hold = set_hour;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (set_hour !== hold || load_seen !== 0) begin
      errors++;
      $display("FAIL timeout_short got hour=%0d loads=%0d want %0d 0", set_hour, load_seen, hold);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 1'b1);
    cur_hour = 5'd5; cur_min = 6'd1; cur_sec = 6'd2;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (edit_field !== 2'd2 || set_hour !== 5'd5 || set_min !== 6'd1 || blink_on !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous got field=%0d hour=%0d min=%0d blink=%b want 2 5 1 1",
               edit_field, set_hour, set_min, blink_on);
    end
  endtask

  task automatic test_reset_mid_edit();
    step(1'b0, 1'b0, 1'b1);
    load_seen = 0;
    cur_hour = 5'd9; cur_min = 6'd8; cur_sec = 6'd7;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (run_en !== 1'b1 || edit_field !== 2'd0 || load !== 1'b0 || blink_on !== 1'b0 ||
        set_hour !== 5'd0 || set_min !== 6'd0 || set_sec !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_edit got run_en=%b field=%0d load=%b blink=%b %0d:%0d:%0d want 1 0 0 0 0:0:0",
               run_en, edit_field, load, blink_on, set_hour, set_min, set_sec);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (load_seen !== 0 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_load got loads=%0d run_en=%b want 0 1", load_seen, run_en);
    end
  endtask

  task automatic test_blink();
    int bad;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (blink_on !== (((k / BL) % 2) == 0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL blink_idle got %0d wrong cycles want 0", bad);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (blink_on !== 1'b1) begin
      errors++;
      $display("FAIL blink_restart got %b want 1", blink_on);
    end
    repeat (BL - 1) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (blink_on !== 1'b1) begin
      errors++;
      $display("FAIL blink_hold got %b want 1", blink_on);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (blink_on !== 1'b0) begin
      errors++;
      $display("FAIL blink_toggle got %b want 0", blink_on);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    step(1'b0, 1'b0, 1'b1);
    cur_hour = 5'd20; cur_min = 6'd50; cur_sec = 6'd0;
    step(1'b0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (set_hour !== 5'((20 + k) % 24)) bad++;
    end
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (set_min !== 6'((50 + k) % 60)) bad++;
    end
    checks++;
    if (bad != 0 || set_hour !== 5'd2) begin
      errors++;
      $display("FAIL back_to_back got %0d wrong increments hour=%0d want 0 2", bad, set_hour);
    end
  endtask

  task automatic test_random();
    int bad;
    int sparse;
    logic s, l, r;
    bad = 0;
    for (int c = 0; c < 4000; c++) begin
      sparse = ((c / 400) % 2);
      cur_hour = 5'($urandom_range(23));
      cur_min  = 6'($urandom_range(59));
      cur_sec  = 6'($urandom_range(59));
      r = ($urandom_range(299) == 0);
      if (sparse != 0) begin
        l = ($urandom_range(149) == 0);
        s = ($urandom_range(119) == 0);
      end else begin
        l = ($urandom_range(9) == 0);
        s = ($urandom_range(2) == 0);
      end
      step(s, l, r);
      checks++;
      if (set_hour !== 5'(m_h) || set_min !== 6'(m_m) || set_sec !== 6'(m_s) ||
          load !== (m_mode == 4) || run_en !== (m_mode == 0) ||
          edit_field !== exp_field() || blink_on !== exp_blink()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random c=%0d got %0d:%0d:%0d load=%b run=%b field=%0d blink=%b want %0d:%0d:%0d load=%b run=%b field=%0d blink=%b",
                   c, set_hour, set_min, set_sec, load, run_en, edit_field, blink_on,
                   m_h, m_m, m_s, (m_mode == 4), (m_mode == 0), exp_field(), exp_blink());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_edit();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid_edit();
    test_blink();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
